// File: rtl/sram_loader_pkg.sv
// Shared definitions for the serial SRAM loader.
//   - FSM state encoding (3-bit)
//   - CTRL_MODE values
//   - SRAM address/data widths and the shift counter width
package sram_loader_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WSHIFT = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RREQ   = 3'd4,
    ST_RWAIT  = 3'd5,
    ST_RSHIFT = 3'd6
  } state_t;

endpackage

// File: rtl/loader_shift_reg.sv
// Shared 9-bit shift path for the address header, write bytes and read bytes.
// Stores W-1 bits; the W-th bit is the live serial input, so shift_val is the
// full W-bit word including the bit being sampled this cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        parallel load of din, clears the bit count
//   shift       shift left by one, taking si into bit 0
//   clr         clear the bit count (the data shift still happens if shift=1)
//   si          serial input
//   din         parallel load data (W-1 bits)
//   shift_val   {stored bits, si}: value completed by the current shift
//   so          serial output, MSB of the stored bits
//   cnt         number of shifts since the last clear/load
module loader_shift_reg
  import sram_loader_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clr,
  input  logic             si,
  input  logic [W-2:0]     din,
  output logic [W-1:0]     shift_val,
  output logic             so,
  output logic [CNT_W-1:0] cnt
);

  logic [W-2:0] q;

  assign shift_val = {q, si};
  assign so        = q[W-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      if (load)       q <= din;
      else if (shift) q <= {q[W-3:0], si};

      if (clr || load) cnt <= '0;
      else if (shift)  cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_serial_loader.sv
// Serial-to-SRAM bridge for the 512x8 single-port SRAM. A session shifts a
// 9-bit start address (MSB first) on CTRL_SI, then either writes bytes (9-clock
// frames: 8 data bits + 1 ignored bit) or reads bytes out on CTRL_SO, with an
// auto-incrementing, wrapping address.
// Optional feature: define LOADER_CHECKSUM_EN to get a mod-256 sum of the bytes
// written in the current write session on CHKSUM; otherwise CHKSUM is 0.
// Handshake: the host may start a session only while CTRL_RDY=1 by raising
// CTRL_BGN with CTRL_MODE valid in the same cycle; CTRL_BGN must then stay high
// for the whole session, and dropping it ends/aborts the session, with CTRL_RDY
// returning high the following cycle.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   CTRL_MODE           00 idle, 01 write, 10 read, 11 reserved
//   CTRL_BGN, CTRL_SI   session enable, serial in
//   Q_SRAM              SRAM read data (valid the cycle after a read strobe)
//   CEN, WEN, A, D      SRAM control, registered one-cycle strobes
//   CTRL_SO, CTRL_RDY   serial out, idle indicator
//   CHKSUM              write checksum
//   DBG_STATE           current FSM state
module sram_serial_loader
  import sram_loader_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = DATA_W,
  parameter int MEMORY_ADDR_WIDTH = ADDR_W  // must equal MEMORY_DATA_WIDTH+1 (shared shifter)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [1:0]                   CTRL_MODE,
  input  logic                         CTRL_BGN,
  input  logic                         CTRL_SI,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q_SRAM,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         CTRL_SO,
  output logic                         CTRL_RDY,
  output logic [MEMORY_DATA_WIDTH-1:0] CHKSUM,
  output logic [2:0]                   DBG_STATE
);

  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int DW = MEMORY_DATA_WIDTH;

  state_t          state, next_state;
  logic [1:0]      mode_q;
  logic            mode_ld;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic            sr_load, sr_shift, sr_clr, sr_so;
  logic [AW-1:0]   sr_val;
  logic [CNT_W-1:0] sr_cnt;
  logic            strobe_wr, strobe_rd;

  loader_shift_reg #(.W(AW)) u_shift (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (sr_load),
    .shift     (sr_shift),
    .clr       (sr_clr),
    .si        (CTRL_SI),
    .din       (Q_SRAM),
    .shift_val (sr_val),
    .so        (sr_so),
    .cnt       (sr_cnt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mode_ld    = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_clr     = 1'b0;
    addr_nxt   = addr_q;
    case (state)
      ST_IDLE: begin
        if (CTRL_BGN && (CTRL_MODE == MODE_WR || CTRL_MODE == MODE_RD)) begin
          next_state = ST_ADDR;
          mode_ld    = 1'b1;
          sr_clr     = 1'b1;
        end
      end
      ST_ADDR: begin
        sr_shift = 1'b1;
        if (sr_cnt == CNT_W'(AW - 1)) begin
          sr_clr     = 1'b1;
          addr_nxt   = sr_val;
          next_state = (mode_q == MODE_WR) ? ST_WSHIFT : ST_RREQ;
        end
      end
      ST_WSHIFT: begin
        sr_shift = 1'b1;
        if (sr_cnt == CNT_W'(DW - 1)) begin
          sr_clr     = 1'b1;
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_nxt   = addr_q + 1'b1;
        next_state = ST_WSHIFT;
      end
      ST_RREQ:  next_state = ST_RWAIT;
      ST_RWAIT: begin
        sr_load    = 1'b1;
        addr_nxt   = addr_q + 1'b1;
        next_state = ST_RSHIFT;
      end
      ST_RSHIFT: begin
        sr_shift = 1'b1;
        if (sr_cnt == CNT_W'(DW - 1)) begin
          sr_clr     = 1'b1;
          next_state = ST_RREQ;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Abort wins over everything; a byte not yet in WRITE is dropped.
    if (state != ST_IDLE && !CTRL_BGN) next_state = ST_IDLE;
  end

  // Strobes are registered from the next state so they line up with the
  // WRITE / RREQ state cycles.
  assign strobe_wr = (next_state == ST_WRITE);
  assign strobe_rd = (next_state == ST_RREQ);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q  <= MODE_IDLE;
      addr_q  <= '0;
      CEN     <= 1'b1;
      WEN     <= 1'b1;
      A       <= '0;
      D       <= '0;
      CTRL_SO <= 1'b0;
    end else begin
      if (mode_ld) mode_q <= CTRL_MODE;
      addr_q <= addr_nxt;
      CEN    <= !(strobe_wr || strobe_rd);
      WEN    <= !strobe_wr;
      if (strobe_wr || strobe_rd) A <= addr_nxt;
      if (strobe_wr) D <= sr_val[DW-1:0];
      // CTRL_SO only moves while shifting, so it holds the last bit during fetch.
      if (state == ST_RSHIFT) CTRL_SO <= sr_so;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] chksum_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              chksum_q <= '0;
    else if (mode_ld && CTRL_MODE == MODE_WR) chksum_q <= '0;
    else if (state == ST_WRITE)              chksum_q <= chksum_q + D;
  end
  assign CHKSUM = chksum_q;
`else
  assign CHKSUM = '0;
`endif

  assign CTRL_RDY  = (state == ST_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_sram_serial_loader.sv
module tb_sram_serial_loader;
  import sram_loader_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] CTRL_MODE = 2'b00;
  logic       CTRL_BGN = 1'b0;
  logic       CTRL_SI = 1'b0;
  logic [7:0] Q_SRAM;
  logic       CEN, WEN, CTRL_SO, CTRL_RDY;
  logic [8:0] A;
  logic [7:0] D, CHKSUM;
  logic [2:0] DBG_STATE;

  int checks = 0;
  int failures = 0;
  int cen_low_cnt = 0;
  int rdy_low_cnt = 0;
  logic [16:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  mem [0:511];

`ifdef LOADER_CHECKSUM_EN
  localparam logic [7:0] EXP_SUM = 8'h01;
`else
  localparam logic [7:0] EXP_SUM = 8'h00;
`endif

  sram_serial_loader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CTRL_MODE (CTRL_MODE),
    .CTRL_BGN  (CTRL_BGN),
    .CTRL_SI   (CTRL_SI),
    .Q_SRAM    (Q_SRAM),
    .CEN       (CEN),
    .WEN       (WEN),
    .A         (A),
    .D         (D),
    .CTRL_SO   (CTRL_SO),
    .CTRL_RDY  (CTRL_RDY),
    .CHKSUM    (CHKSUM),
    .DBG_STATE (DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // SRAM model: read data valid the cycle after the read strobe
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q_SRAM <= mem[A];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  logic       so_take = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         rd_bits = 0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      so_take = 1'b0;
      rd_bits = 0;
    end else begin
      if (!CEN) cen_low_cnt++;
      if (!CTRL_RDY) rdy_low_cnt++;
      if (!CEN && !WEN) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write got A=%0h D=%0h required none", A, D);
        end else begin
          check("write_strobe_addr_data", 32'({A, D}), 32'(exp_wr_q.pop_front()));
        end
      end
      if (so_take) begin
        rd_byte = {rd_byte[6:0], CTRL_SO};
        rd_bits++;
        if (rd_bits == 8) begin
          rd_bits = 0;
          if (exp_rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read_byte got=%0h required none", rd_byte);
          end else begin
            check("read_serial_byte", 32'(rd_byte), 32'(exp_rd_q.pop_front()));
          end
        end
      end
      // CTRL_SO is registered: the bit shifted in an RSHIFT cycle shows the cycle after
      so_take = (DBG_STATE == ST_RSHIFT);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    CTRL_SI = b;
    tick();
  endtask

  task automatic shift_addr(input logic [8:0] a);
    for (int i = 8; i >= 0; i--) shift_bit(a[i]);
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) shift_bit(b[i]);
    shift_bit(1'b0);  // slot taken by the WRITE cycle
  endtask

  task automatic begin_session(input logic [1:0] m);
    CTRL_MODE = m;
    CTRL_BGN  = 1'b1;
    tick();
  endtask

  task automatic end_session();
    CTRL_BGN = 1'b0;
    CTRL_SI  = 1'b0;
    tick();
    tick();
  endtask

  task automatic write_burst(input logic [8:0] a0, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [8:0] a1);
    begin_session(MODE_WR);
    shift_addr(a0);
    exp_wr_q.push_back({a0, b0});
    shift_byte(b0);
    exp_wr_q.push_back({a1, b1});
    shift_byte(b1);
    end_session();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cen"},    32'(CEN),       32'h1);
    check({tag, "_wen"},    32'(WEN),       32'h1);
    check({tag, "_a"},      32'(A),         32'h0);
    check({tag, "_d"},      32'(D),         32'h0);
    check({tag, "_so"},     32'(CTRL_SO),   32'h0);
    check({tag, "_rdy"},    32'(CTRL_RDY),  32'h1);
    check({tag, "_chksum"}, 32'(CHKSUM),    32'h0);
    check({tag, "_state"},  32'(DBG_STATE), 32'(ST_IDLE));
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int c0, r0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_values("por");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();

    // write A5,3C at 010
    write_burst(9'h010, 8'hA5, 8'h3C, 9'h011);

    // read them back
    begin_session(MODE_RD);
    exp_rd_q.push_back(8'hA5);
    exp_rd_q.push_back(8'h3C);
    shift_addr(9'h010);
    repeat (21) tick();
    end_session();

    // reset in the middle of a write byte
    begin_session(MODE_WR);
    shift_addr(9'h080);
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    c0 = cen_low_cnt;
    RST_N    = 1'b0;
    CTRL_BGN = 1'b0;
    @(negedge CLK);
    check_reset_values("mid_reset");
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) shift_bit(i[0]);
    check("mid_reset_no_strobe", 32'(cen_low_cnt - c0), 32'h0);

    // address wrap
    write_burst(9'h1FF, 8'h11, 8'h22, 9'h000);

    // abort after 5 bits of a byte
    begin_session(MODE_WR);
    shift_addr(9'h040);
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    check("abort_rdy_busy", 32'(CTRL_RDY), 32'h0);
    c0 = cen_low_cnt;
    CTRL_BGN = 1'b0;
    tick();
    check("abort_rdy_next", 32'(CTRL_RDY), 32'h1);
    repeat (12) tick();
    check("abort_no_strobe", 32'(cen_low_cnt - c0), 32'h0);

    // checksum
    write_burst(9'h100, 8'hFF, 8'h02, 9'h101);
    check("chksum", 32'(CHKSUM), 32'(EXP_SUM));

    // reserved mode
    c0 = cen_low_cnt;
    r0 = rdy_low_cnt;
    CTRL_MODE = MODE_RSV;
    CTRL_BGN  = 1'b1;
    repeat (20) tick();
    check("reserved_no_strobe", 32'(cen_low_cnt - c0), 32'h0);
    check("reserved_rdy_held", 32'(rdy_low_cnt - r0), 32'h0);
    check("reserved_state", 32'(DBG_STATE), 32'(ST_IDLE));
    CTRL_BGN = 1'b0;
    repeat (3) tick();

    // report
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
